// File: rtl/decode_stage.sv
// ID stage: opcode decode, 32x32 register file, branch target, and the ID/EX pipeline register.
// Optional REGFILE_BYPASS_EN: same-cycle writeback data is forwarded to the register reads.
module decode_stage #(
    parameter int NREGS = 32,
    parameter int PCW   = 5,
    parameter int GHRW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_d,
    input  logic [PCW-1:0]  pc_d,
    input  logic            prediction_d,
    input  logic            hit_d,
    input  logic [GHRW-1:0] ghr_d,
    input  logic            id_ex_write,
    input  logic            id_ex_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic [5:0]      opcode_o,
    output logic [31:0]     target_addr_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [31:0]     rs_data_e,
    output logic [31:0]     rt_data_e,
    output logic [31:0]     imm_e,
    output logic [4:0]      rs_e,
    output logic [4:0]      rt_e,
    output logic [4:0]      rd_e,
    output logic [5:0]      funct_e,
    output logic [PCW-1:0]  pc_e,
    output logic            prediction_e,
    output logic            hit_e,
    output logic [GHRW-1:0] pc_xor_ghr_e,
    output logic            reg_write_e,
    output logic            mem_read_e,
    output logic            mem_write_e,
    output logic            mem_to_reg_e,
    output logic            alu_src_e,
    output logic            reg_dst_e,
    output logic            branch_e,
    output logic            bne_e,
    output logic            jump_e,
    output logic            link_e,
    output logic            rtype_e
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
        logic branch;
        logic bne;
        logic jump;
        logic link;
        logic rtype;
    } ctrl_t;

    logic [31:0] regs [NREGS];
    logic [31:0] imm_sext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    ctrl_t       ctrl_d;
    ctrl_t       ctrl_e;

    assign opcode_o      = instr_d[31:26];
    assign rs_o          = instr_d[25:21];
    assign rt_o          = instr_d[20:16];
    assign imm_sext      = {{16{instr_d[15]}}, instr_d[15:0]};
    assign target_addr_o = {{(32-PCW){1'b0}}, pc_d} + 32'd1 + imm_sext;

    always_comb begin
        ctrl_d = '0;
        case (opcode_o)
            OP_RTYPE: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.rtype = 1'b1; end
            OP_ADDI:  begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_src    = 1'b1;
            end
            OP_SW:    begin ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1; end
            OP_BEQ:   ctrl_d.branch = 1'b1;
            OP_BNE:   begin ctrl_d.branch = 1'b1; ctrl_d.bne = 1'b1; end
            OP_J:     ctrl_d.jump = 1'b1;
            OP_JAL:   begin ctrl_d.jump = 1'b1; ctrl_d.link = 1'b1; ctrl_d.reg_write = 1'b1; end
            default:  ctrl_d = '0;
        endcase
    end

    // Reset clears the whole array; a writeback in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rs_val = (rs_o == '0) ? '0 : (wb_we && wb_addr == rs_o) ? wb_data : regs[rs_o];
        rt_val = (rt_o == '0) ? '0 : (wb_we && wb_addr == rt_o) ? wb_data : regs[rt_o];
`else
        rs_val = (rs_o == '0) ? '0 : regs[rs_o];
        rt_val = (rt_o == '0) ? '0 : regs[rt_o];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || id_ex_flush) begin
            rs_data_e    <= '0;
            rt_data_e    <= '0;
            imm_e        <= '0;
            rs_e         <= '0;
            rt_e         <= '0;
            rd_e         <= '0;
            funct_e      <= '0;
            pc_e         <= '0;
            prediction_e <= 1'b0;
            hit_e        <= 1'b0;
            pc_xor_ghr_e <= '0;
            ctrl_e       <= '0;
        end else if (id_ex_write) begin
            rs_data_e    <= rs_val;
            rt_data_e    <= rt_val;
            imm_e        <= imm_sext;
            rs_e         <= rs_o;
            rt_e         <= rt_o;
            rd_e         <= instr_d[15:11];
            funct_e      <= instr_d[5:0];
            pc_e         <= pc_d;
            prediction_e <= prediction_d;
            hit_e        <= hit_d;
            pc_xor_ghr_e <= pc_d[GHRW-1:0] ^ ghr_d;
            ctrl_e       <= ctrl_d;
        end
    end

    assign reg_write_e  = ctrl_e.reg_write;
    assign mem_read_e   = ctrl_e.mem_read;
    assign mem_write_e  = ctrl_e.mem_write;
    assign mem_to_reg_e = ctrl_e.mem_to_reg;
    assign alu_src_e    = ctrl_e.alu_src;
    assign reg_dst_e    = ctrl_e.reg_dst;
    assign branch_e     = ctrl_e.branch;
    assign bne_e        = ctrl_e.bne;
    assign jump_e       = ctrl_e.jump;
    assign link_e       = ctrl_e.link;
    assign rtype_e      = ctrl_e.rtype;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued at drive time and
// compared one cycle later; combinational outputs are checked in the drive cycle.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_d = '0;
    logic [4:0]  pc_d = '0;
    logic        prediction_d = 1'b0;
    logic        hit_d = 1'b0;
    logic [3:0]  ghr_d = '0;
    logic        id_ex_write = 1'b0;
    logic        id_ex_flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  opcode_o;
    logic [31:0] target_addr_o;
    logic [4:0]  rs_o, rt_o;
    logic [31:0] rs_data_e, rt_data_e, imm_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [5:0]  funct_e;
    logic [4:0]  pc_e;
    logic        prediction_e, hit_e;
    logic [3:0]  pc_xor_ghr_e;
    logic        reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e, alu_src_e, reg_dst_e;
    logic        branch_e, bne_e, jump_e, link_e, rtype_e;

    decode_stage #(.NREGS(32), .PCW(5), .GHRW(4)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d),
        .prediction_d(prediction_d), .hit_d(hit_d), .ghr_d(ghr_d),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .opcode_o(opcode_o), .target_addr_o(target_addr_o), .rs_o(rs_o), .rt_o(rt_o),
        .rs_data_e(rs_data_e), .rt_data_e(rt_data_e), .imm_e(imm_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .funct_e(funct_e), .pc_e(pc_e),
        .prediction_e(prediction_e), .hit_e(hit_e), .pc_xor_ghr_e(pc_xor_ghr_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .mem_to_reg_e(mem_to_reg_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .branch_e(branch_e), .bne_e(bne_e), .jump_e(jump_e), .link_e(link_e),
        .rtype_e(rtype_e)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  pc;
        logic        pred;
        logic        hit;
        logic [3:0]  ghr;
        logic        wr;
        logic        fl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rst;
    } stim_t;

    typedef struct packed {
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [4:0]  pc;
        logic        pred;
        logic        hit;
        logic [3:0]  pxg;
        logic [10:0] ctrl;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] mreg [32];

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] EXP_BYP = 32'h0000_00AA;
`else
    localparam logic [31:0] EXP_BYP = 32'h0000_0011;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit order: reg_write mem_read mem_write mem_to_reg alu_src reg_dst branch bne jump link rtype
    function automatic logic [10:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 11'b10000100001;
            6'h08:   return 11'b10001000000;
            6'h23:   return 11'b11011000000;
            6'h2B:   return 11'b00101000000;
            6'h04:   return 11'b00000010000;
            6'h05:   return 11'b00000011000;
            6'h02:   return 11'b00000000100;
            6'h03:   return 11'b10000000110;
            default: return 11'b00000000000;
        endcase
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a, input stim_t s);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (s.we && s.wa == a) return s.wd;
`endif
        return mreg[a];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.wr = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input stim_t s);
        exp_t        e;
        logic [31:0] tgt;
        @(negedge clk);
        reset = s.rst;  instr_d = s.instr; pc_d = s.pc; prediction_d = s.pred; hit_d = s.hit;
        ghr_d = s.ghr;  id_ex_write = s.wr; id_ex_flush = s.fl;
        wb_we = s.we;   wb_addr = s.wa;     wb_data = s.wd;
        #1;
        tgt = 32'(s.pc) + 32'd1 + 32'($signed(s.instr[15:0]));
        check("opcode_o", 32'(opcode_o), 32'(s.instr[31:26]));
        check("rs_o", 32'(rs_o), 32'(s.instr[25:21]));
        check("rt_o", 32'(rt_o), 32'(s.instr[20:16]));
        check("target_addr_o", target_addr_o, tgt);
        e = '0;
        if (s.rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
        end else begin
            if (s.fl) e = '0;
            else if (s.wr) begin
                e.rsd   = rd_model(s.instr[25:21], s);
                e.rtd   = rd_model(s.instr[20:16], s);
                e.imm   = 32'($signed(s.instr[15:0]));
                e.rs    = s.instr[25:21];
                e.rt    = s.instr[20:16];
                e.rd    = s.instr[15:11];
                e.funct = s.instr[5:0];
                e.pc    = s.pc;
                e.pred  = s.pred;
                e.hit   = s.hit;
                e.pxg   = s.pc[3:0] ^ s.ghr;
                e.ctrl  = ctrl_of(s.instr[31:26]);
            end else e = cur;
            if (s.we && s.wa != 5'd0) mreg[s.wa] = s.wd;
        end
        cur = e;
        sb.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ctrl_e", 32'({reg_write_e, mem_read_e, mem_write_e, mem_to_reg_e, alu_src_e,
                             reg_dst_e, branch_e, bne_e, jump_e, link_e, rtype_e}), 32'(e.ctrl));
        check("rs_data_e", rs_data_e, e.rsd);
        check("rt_data_e", rt_data_e, e.rtd);
        check("imm_e", imm_e, e.imm);
        check("fields_e", {rs_e, rt_e, rd_e, funct_e, pc_e, prediction_e, hit_e},
              {e.rs, e.rt, e.rd, e.funct, e.pc, e.pred, e.hit});
        check("pc_xor_ghr_e", 32'(pc_xor_ghr_e), 32'(e.pxg));
    endtask

    task automatic step(input stim_t s);
        drive(s);
        settle();
    endtask

    initial begin
        stim_t s;
        logic [5:0] ops [10];
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h10};
        cur = '0;

        // Reset with a concurrent write that must be dropped
        s = idle(); s.rst = 1'b1; s.we = 1'b1; s.wa = 5'd9; s.wd = 32'hDEAD_BEEF;
        s.instr = 32'hFFFF_FFFF; s.pc = 5'd7;
        step(s);
        check("reset_clears_ctrl", 32'({reg_write_e, jump_e, branch_e}), 32'd0);
        step(idle());
        s = idle(); s.instr = rtype(5'd9, 5'd31, 5'd1); step(s);
        check("r9_after_reset", rs_data_e, 32'd0);
        for (int i = 1; i < 31; i += 4) begin
            s = idle(); s.instr = rtype(5'(i), 5'(i + 1), 5'd2); step(s);
        end

        s = idle(); s.we = 1'b1; s.wa = 5'd5; s.wd = 32'h1234; step(s);
        s = idle(); s.instr = rtype(5'd5, 5'd0, 5'd3); step(s);
        check("add_rs5", rs_data_e, 32'h1234);
        s = idle(); s.we = 1'b1; s.wa = 5'd0; s.wd = 32'd7; step(s);
        s = idle(); s.instr = rtype(5'd0, 5'd0, 5'd4); step(s);
        check("r0_reads_zero", rs_data_e, 32'd0);

        s = idle(); s.instr = itype(6'h04, 5'd1, 5'd2, 16'hFFFE); s.pc = 5'd3;
        drive(s); check("beq_target_back", target_addr_o, 32'd2); settle();
        check("beq_bits", 32'({branch_e, bne_e}), 32'b10);
        s = idle(); s.instr = itype(6'h05, 5'd1, 5'd2, 16'h0005); s.pc = 5'd31;
        drive(s); check("bne_target_fwd", target_addr_o, 32'd37); settle();

        // Load, hold for two cycles with new IF/ID content, then flush while stalled
        s = idle(); s.instr = itype(6'h23, 5'd5, 5'd6, 16'h0010); s.pc = 5'd12; s.hit = 1'b1; step(s);
        s = idle(); s.wr = 1'b0; s.instr = itype(6'h2B, 5'd1, 5'd2, 16'h0001);
        s.we = 1'b1; s.wa = 5'd6; s.wd = 32'h55; step(s); step(s);
        check("lw_held", 32'({mem_read_e, mem_write_e}), 32'b10);
        s.we = 1'b0; s.fl = 1'b1; step(s);
        s = idle(); s.fl = 1'b1; s.instr = rtype(5'd6, 5'd5, 5'd1); s.pred = 1'b1; step(s);

        s = idle(); s.we = 1'b1; s.wa = 5'd7; s.wd = 32'h11; step(s);
        s = idle(); s.we = 1'b1; s.wa = 5'd7; s.wd = 32'hAA; s.instr = rtype(5'd7, 5'd7, 5'd1); step(s);
        check("same_cycle_wb", rs_data_e, EXP_BYP);

        s = idle(); s.instr = {6'h03, 26'h0000_123}; s.pc = 5'h1A; s.ghr = 4'h5; s.pred = 1'b1; step(s);
        check("pc_xor_ghr", 32'(pc_xor_ghr_e), 32'hF);
        check("jal_bits", 32'({jump_e, link_e, reg_write_e}), 32'b111);

        for (int n = 0; n < 60; n++) begin
            s = '0;
            s.instr = {ops[$urandom_range(0, 9)], 26'($urandom)};
            s.pc = 5'($urandom); s.pred = 1'($urandom); s.hit = 1'($urandom); s.ghr = 4'($urandom);
            s.wr = ($urandom_range(0, 3) != 0); s.fl = ($urandom_range(0, 7) == 0);
            s.we = 1'($urandom); s.wa = 5'($urandom); s.wd = $urandom;
            s.rst = (n == 40);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
